// File: rtl/alarm_chime_ctrl.sv
// alarm_chime_ctrl: qualifies a level Alarm, then drives BEEP_MAX timed beeps and holds the lamp.
// Define CHIME_MUTE_EN to let an Ack pulse during beeping silence the chime (MUTED state).
module alarm_chime_ctrl #(
  parameter int DLY_CYC  = 4,
  parameter int ON_CYC   = 3,
  parameter int OFF_CYC  = 2,
  parameter int BEEP_MAX = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Alarm,
  input  logic       Ack,
  output logic       Buzzer,
  output logic       Lamp,
  output logic [3:0] BeepCnt,
  output logic [2:0] State
);
  typedef enum logic [2:0] {IDLE = 3'd0, QUAL = 3'd1, ON = 3'd2, OFF = 3'd3, HOLD = 3'd4, MUTED = 3'd5} state_t;
  state_t state, nxt;
  logic [7:0] tmr, tmr_n;
  logic [3:0] cnt, cnt_n;
  logic mute;
`ifdef CHIME_MUTE_EN
  assign mute = Ack;
`else
  logic unused_ack;
  assign unused_ack = Ack;
  assign mute = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tmr <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      tmr <= tmr_n;
      cnt <= cnt_n;
    end
  always_comb begin
    nxt = state;
    tmr_n = tmr;
    cnt_n = cnt;
    // Alarm dropping ends the episode from anywhere, ahead of Ack
    if (state != IDLE && !Alarm) begin
      nxt = IDLE;
      tmr_n = '0;
      cnt_n = '0;
    end else
      case (state)
        IDLE: if (Alarm) begin
          nxt = QUAL;
          tmr_n = '0;
          cnt_n = '0;
        end
        QUAL: begin
          nxt = tmr == 8'(DLY_CYC - 1) ? ON : QUAL;
          tmr_n = tmr == 8'(DLY_CYC - 1) ? 8'd0 : tmr + 8'd1;
        end
        ON: if (mute) begin
          nxt = MUTED;
          tmr_n = '0;
        end else if (tmr == 8'(ON_CYC - 1)) begin
          nxt = OFF;
          tmr_n = '0;
          cnt_n = cnt == 4'(BEEP_MAX) ? cnt : cnt + 4'd1;
        end else tmr_n = tmr + 8'd1;
        OFF: if (mute) begin
          nxt = MUTED;
          tmr_n = '0;
        end else if (tmr == 8'(OFF_CYC - 1)) begin
          nxt = cnt == 4'(BEEP_MAX) ? HOLD : ON;
          tmr_n = '0;
        end else tmr_n = tmr + 8'd1;
        HOLD: nxt = HOLD;
`ifdef CHIME_MUTE_EN
        MUTED: nxt = MUTED;
`endif
        default: begin
          nxt = IDLE;
          tmr_n = '0;
          cnt_n = '0;
        end
      endcase
  end
  assign Buzzer  = state == ON;
  assign Lamp    = state == ON || state == OFF || state == HOLD || state == MUTED;
  assign BeepCnt = cnt;
  assign State   = state;
endmodule

// File: tb/tb_alarm_chime_ctrl.sv
// tb_alarm_chime_ctrl: directed and random checks against an episode-age reference model.
module tb_alarm_chime_ctrl;
  localparam int DLY = 4, ONC = 3, OFFC = 2, BM = 3, P = ONC + OFFC;
  logic clk = 0, rst_n = 0, Alarm = 0, Ack = 0;
  logic Buzzer, Lamp;
  logic [3:0] BeepCnt;
  logic [2:0] State;
  int n_cmp = 0, n_bad = 0;
  int age = -1, mcnt = 0;
  bit muted = 0;

  alarm_chime_ctrl dut (.clk(clk), .rst_n(rst_n), .Alarm(Alarm), .Ack(Ack),
    .Buzzer(Buzzer), .Lamp(Lamp), .BeepCnt(BeepCnt), .State(State));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected behaviour as a function of edges elapsed since Alarm was first sampled high
  function automatic int m_state();
    if (age < 0) return 0;
    if (muted) return 5;
    if (age < DLY) return 1;
    if ((age - DLY) / P >= BM) return 4;
    return (age - DLY) % P < ONC ? 2 : 3;
  endfunction

  function automatic int m_cnt();
    int t;
    if (age < 0) return 0;
    if (muted) return mcnt;
    if (age < DLY) return 0;
    t = age - DLY;
    if (t / P >= BM) return BM;
    return t % P < ONC ? t / P : t / P + 1;
  endfunction

  task automatic model_edge(input bit a, input bit k);
    bit m;
    int st;
    m = 0;
    st = m_state();
    if (!a) begin
      age = -1;
      muted = 0;
    end else if (age < 0) begin
      age = 0;
      muted = 0;
    end else if (!muted) begin
`ifdef CHIME_MUTE_EN
      m = k && (st == 2 || st == 3);
`endif
      if (m) begin
        mcnt = m_cnt();
        muted = 1;
      end else age++;
    end
  endtask

  task automatic check_all(input string tag);
    int st;
    st = m_state();
    chk({tag, ".state"}, int'(State), st);
    chk({tag, ".buzzer"}, int'(Buzzer), int'(st == 2));
    chk({tag, ".lamp"}, int'(Lamp), int'(st >= 2));
    chk({tag, ".cnt"}, int'(BeepCnt), m_cnt());
  endtask

  task automatic step(input bit a, input bit k, input string tag);
    Alarm = a;
    Ack = k;
    @(posedge clk);
    model_edge(a, k);
    #1 check_all(tag);
  endtask

  task automatic mid_reset(input string tag);
    #2 rst_n = 0;
    #1;
    age = -1;
    muted = 0;
    check_all(tag);
    #1 rst_n = 1;
  endtask

  initial begin
    #2 check_all("reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    for (int e = 0; e <= 22; e++) begin
      step(1, 0, "seq28");
      if (e == 4 || e == 9 || e == 14) chk("seq28.beep_start", int'(Buzzer), 1);
      if (e == 19) chk("seq28.hold", int'(State), 4);
    end
    step(0, 0, "drop");
    for (int e = 0; e <= 3; e++) step(e <= 2, 0, "short");
    chk("short.idle", int'(State), 0);
    for (int e = 0; e <= 11; e++) step(e != 11, 0, "drop_on");
    chk("drop_on.cnt", int'(BeepCnt), 0);
    step(0, 0, "gap");
    for (int e = 0; e <= 6; e++) step(1, e == 5, "ack5");
`ifdef CHIME_MUTE_EN
    chk("ack5.muted", int'(State), 5);
`else
    chk("ack5.ignored", int'(Buzzer), 1);
`endif
    step(0, 0, "ack5.release");
    for (int e = 0; e <= 5; e++) step(e != 5, e == 5, "ack_drop");
    chk("ack_drop.idle", int'(State), 0);
    for (int e = 0; e <= 5; e++) step(1, 0, "pre_rst");
    mid_reset("rst_mid");
    for (int e = 0; e <= 5; e++) begin
      step(1, 0, "post_rst");
      if (e == 3) chk("post_rst.quiet", int'(Buzzer), 0);
      if (e == 4) chk("post_rst.rise", int'(Buzzer), 1);
    end
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0, "rand");
      if ($urandom_range(0, 249) == 0) mid_reset("rand_rst");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alarm_chime_ctrl.md
ALARM_CHIME_CTRL -- requirements
Module: alarm_chime_ctrl

Interface
REQ-001 Parameter DLY_CYC, default 4: cycles Alarm must stay high before the first beep (legal 1..255).
REQ-002 Parameter ON_CYC, default 3: buzzer-on cycles per beep (legal 1..255).
REQ-003 Parameter OFF_CYC, default 2: buzzer-off cycles after each beep (legal 1..255).
REQ-004 Parameter BEEP_MAX, default 3: beeps per alarm episode (legal 1..15).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 Alarm  input  1  level warning from the upstream car-warning logic, synchronous to clk.
REQ-008 Ack  input  1  driver mute button, one-cycle pulse, synchronous to clk.
REQ-009 Buzzer  output  1  chime drive, high while beeping.
REQ-010 Lamp  output  1  dashboard warning lamp.
REQ-011 BeepCnt  output  4  beeps completed in the current episode.
REQ-012 State  output  3  current FSM state: IDLE=0, QUAL=1, ON=2, OFF=3, HOLD=4, MUTED=5.

Function
REQ-013 Buzzer, Lamp and State are Moore outputs decoded only from the state register; they are never combinational paths from inputs.
REQ-014 Buzzer=1 only in ON; Lamp=1 in ON, OFF, HOLD and MUTED; both are 0 in IDLE and QUAL.
REQ-015 IDLE: Alarm=1 sampled -> QUAL with the 8-bit timer cleared; otherwise stay in IDLE.
REQ-016 QUAL: Alarm=0 -> IDLE; timer==DLY_CYC-1 with Alarm=1 -> ON with timer cleared; otherwise timer increments.
REQ-017 ON: timer==ON_CYC-1 -> OFF, timer cleared, BeepCnt incremented on that same edge.
REQ-018 OFF: timer==OFF_CYC-1 -> HOLD if BeepCnt==BEEP_MAX, otherwise ON; timer cleared on either exit.
REQ-019 HOLD and MUTED are left only through Alarm=0 -> IDLE.
REQ-020 Alarm=0 in any non-IDLE state -> IDLE on the next edge, with timer and BeepCnt cleared; this has priority over every other transition and over Ack.
REQ-021 Alarm re-asserting after IDLE starts a new episode from QUAL with BeepCnt=0; there is no carry-over.
REQ-022 The timer and BeepCnt never wrap; BeepCnt saturates at BEEP_MAX.
REQ-023 States 6 and 7 are illegal; an illegal state -> IDLE on the next edge.
REQ-024 Latency: the first rising edge of Buzzer occurs exactly DLY_CYC cycles after the edge that first samples Alarm=1.

Reset
REQ-025 rst_n=0 asynchronously forces State=IDLE, timer=0, BeepCnt=0, Buzzer=0 and Lamp=0, independent of clk.
REQ-026 Reset asserted mid-beep drops Buzzer immediately; after reset release the block restarts in IDLE and requalifies Alarm from the beginning.

Configuration
REQ-027 The macro CHIME_MUTE_EN controls the Ack input.
- Defined: Ack=1 in ON or OFF -> MUTED on the next edge (Buzzer=0, Lamp=1, BeepCnt held); Ack is ignored in every other state.
- Undefined: Ack is ignored in all states, MUTED is unreachable, and the state-5 encoding is handled as illegal per REQ-023.

Verification
REQ-028 Reset, then Alarm=1 from edge 0 and held, defaults: Buzzer=1 on edges 4-6, 9-11 and 14-16, and 0 on all other edges; State=HOLD from edge 19 with Lamp=1, Buzzer=0, BeepCnt=3.
REQ-029 Alarm=1 for edges 0-2, then 0: State goes 1,1,1,0; Buzzer and Lamp never assert.
REQ-030 Alarm held, Alarm=0 at edge 10 (inside the second ON): edge 11 State=IDLE, Buzzer=0, Lamp=0, BeepCnt=0.
REQ-031 Build with CHIME_MUTE_EN, Alarm held, Ack pulse at edge 5: State=MUTED at edge 6 with Buzzer=0, Lamp=1, BeepCnt=0; Alarm=0 afterwards -> IDLE. Same stimulus without the macro: waveform identical to REQ-028.
REQ-032 Alarm=0 and Ack=1 on the same edge while in ON: next state is IDLE, not MUTED.
REQ-033 rst_n pulsed low between clock edges at edge 5.5 while Buzzer=1: Buzzer=0 before the next edge; after release with Alarm still held, Buzzer first rises 4 edges after the first sampling edge.
